// File: rtl/mdu_ctrl.sv
// mdu_ctrl: sequencing controller for the E-stage multiply/divide unit.
// Times mult/div latency and drives busy, HI/LO write enables, completion and
// the D-stage stall for MDU-dependent instructions. Contains no arithmetic.
// Optional feature: define MDU_ABORT_EN to add the abort input, which kills an
// in-flight long op or suppresses a start in the same cycle.
module mdu_ctrl #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [3:0] mdu_op,
  input  logic       div_zero,
  input  logic       md_in_d,
`ifdef MDU_ABORT_EN
  input  logic       abort,
`endif
  output logic       busy,
  output logic [3:0] op_q,
  output logic       hi_we,
  output logic       lo_we,
  output logic       done,
  output logic       stall_md
);

  localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W      = $clog2(MAX_CYCLES) + 1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             divz_q;

  logic kill;
  logic start_ok;
  logic is_long;
  logic is_div;
  logic start_long;
  logic cnt_zero;

`ifdef MDU_ABORT_EN
  assign kill = abort;
`else
  assign kill = 1'b0;
`endif

  // Decode of the incoming op; a start is only honoured out of reset and without abort.
  assign start_ok   = start & reset & ~kill;
  assign is_long    = (mdu_op >= 4'd1) && (mdu_op <= 4'd4);
  assign is_div     = (mdu_op == 4'd3) || (mdu_op == 4'd4);
  assign start_long = start_ok & is_long;
  assign cnt_zero   = (cnt == '0);

  // Sequencer: latch a long op in IDLE, count its latency down in RUN.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      cnt    <= '0;
      busy   <= 1'b0;
      op_q   <= '0;
      divz_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_long) begin
            state  <= RUN;
            busy   <= 1'b1;
            op_q   <= mdu_op;
            divz_q <= div_zero & is_div;
            cnt    <= is_div ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
          end
        end
        RUN: begin
          if (kill || cnt_zero) begin
            state <= IDLE;
            busy  <= 1'b0;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Write enables: long-op result in its last RUN cycle, mthi/mtlo straight from IDLE.
  always_comb begin
    hi_we = 1'b0;
    lo_we = 1'b0;
    done  = 1'b0;
    if (state == RUN) begin
      if (cnt_zero && !divz_q && !kill) begin
        hi_we = 1'b1;
        lo_we = 1'b1;
        done  = 1'b1;
      end
    end else begin
      hi_we = start_ok & (mdu_op == 4'd5);
      lo_we = start_ok & (mdu_op == 4'd6);
    end
  end

  // Hold dependent D-stage instructions while a long op is starting or in flight.
  assign stall_md = md_in_d & (busy | start_long);

endmodule
